sm_config_loader: RTL and testbench

- AXI4-Lite slave that configures the Sherman-Morrison target detector.
- Takes the target signature and the initial inverse-correlation matrix as streams of 32-bit register writes and converts them into indexed write strobes for the core's signature and matrix memories.
- Gates the core enable until both memories are completely loaded.
- Sits between the AXI interconnect (VIP master in simulation) and the detector core.

---
 rtl/sm_cfg_pkg.sv | 13 +
 rtl/sm_cfg_index_counter.sv | 26 ++
 rtl/sm_config_loader.sv | 115 +++++++++++
 tb/tb_sm_config_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sm_cfg_pkg.sv
// sm_cfg_pkg: register map, AXI response codes, write FSM states and index-width helper for the config loader.
package sm_cfg_pkg;
  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_MATRIX    = 2'd1;
  localparam logic [1:0] REG_SIGNATURE = 2'd2;
  localparam logic [1:0] REG_STATUS    = 2'd3;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sm_cfg_index_counter.sv
// sm_cfg_index_counter: write index that counts to LIMIT, wraps to 0 and latches a loaded flag.
module sm_cfg_index_counter
  import sm_cfg_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         inc,
  output logic [idx_width(LIMIT)-1:0]  cnt,
  output logic                         loaded
);
  localparam int W = idx_width(LIMIT);
  logic last;
  assign last = cnt == W'(LIMIT - 1);
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt    <= '0;
      loaded <= 1'b0;
    end else if (inc && !loaded) begin
      cnt    <= last ? '0 : cnt + W'(1);
      loaded <= last;
    end
  end
endmodule

// File: rtl/sm_config_loader.sv
// sm_config_loader: AXI4-Lite slave streaming signature/matrix words into indexed memory strobes and gating core enable.
module sm_config_loader
  import sm_cfg_pkg::*;
#(
  parameter int NUM_BANDS              = 16,
  parameter int CORRELATION_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH     = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               s_axi_awaddr,
  input  logic                                        s_axi_awvalid,
  output logic                                        s_axi_awready,
  input  logic [31:0]                                 s_axi_wdata,
  input  logic                                        s_axi_wvalid,
  output logic                                        s_axi_wready,
  output logic [1:0]                                  s_axi_bresp,
  output logic                                        s_axi_bvalid,
  input  logic                                        s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               s_axi_araddr,
  input  logic                                        s_axi_arvalid,
  output logic                                        s_axi_arready,
  output logic [31:0]                                 s_axi_rdata,
  output logic [1:0]                                  s_axi_rresp,
  output logic                                        s_axi_rvalid,
  input  logic                                        s_axi_rready,
  output logic                                        sig_wr_en,
  output logic [idx_width(NUM_BANDS)-1:0]             sig_wr_addr,
  output logic                                        mat_wr_en,
  output logic [idx_width(NUM_BANDS*NUM_BANDS)-1:0]   mat_wr_addr,
  output logic [CORRELATION_DATA_WIDTH-1:0]           cfg_wr_data,
  output logic                                        core_enable
);
  localparam int SW = idx_width(NUM_BANDS);
  localparam int MW = idx_width(NUM_BANDS * NUM_BANDS);
  w_state_t state, state_n;
  logic rdy_en;
  logic [1:0] aw_q, addr;
  logic [31:0] w_q, data, rd_val;
  logic aw_hs, w_hs, ar_hs, fire, ctrl_wr, clr, sig_go, mat_go;
  logic [1:0] resp_n;
  logic [SW-1:0] sig_cnt;
  logic [MW-1:0] mat_cnt;
  logic sig_loaded, mat_loaded;
  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};
  // readies stay low while reset is held, then open on the first cycle out of reset
  assign s_axi_awready = rdy_en && (state == W_IDLE || state == W_GOT_W);
  assign s_axi_wready  = rdy_en && (state == W_IDLE || state == W_GOT_AW);
  assign s_axi_bvalid  = state == W_RESP;
  assign s_axi_arready = rdy_en && !s_axi_rvalid;
  assign s_axi_rresp   = RESP_OKAY;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  always_comb begin
    addr    = aw_hs ? s_axi_awaddr[3:2] : aw_q;
    data    = w_hs ? s_axi_wdata : w_q;
    fire    = (aw_hs || state == W_GOT_AW) && (w_hs || state == W_GOT_W);
    ctrl_wr = fire && addr == REG_CTRL;
    clr     = ctrl_wr && data[1];
    sig_go  = fire && addr == REG_SIGNATURE && !sig_loaded;
    mat_go  = fire && addr == REG_MATRIX && !mat_loaded;
    resp_n  = (addr == REG_STATUS || (addr == REG_SIGNATURE && sig_loaded) || (addr == REG_MATRIX && mat_loaded) ||
               (addr == REG_CTRL && data[1:0] == 2'b01 && !(sig_loaded && mat_loaded))) ? RESP_SLVERR : RESP_OKAY;
    state_n = fire ? W_RESP :
              (state == W_IDLE && aw_hs) ? W_GOT_AW :
              (state == W_IDLE && w_hs) ? W_GOT_W :
              (state == W_RESP && s_axi_bready) ? W_IDLE : state;
    rd_val  = s_axi_araddr[3:2] == REG_CTRL ? {31'b0, core_enable} :
              s_axi_araddr[3:2] == REG_STATUS ? {5'b0, core_enable, mat_loaded, sig_loaded, 16'(mat_cnt), 8'(sig_cnt)} : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= W_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_en       <= 1'b0;
      aw_q         <= '0;
      w_q          <= '0;
      s_axi_bresp  <= RESP_OKAY;
      sig_wr_en    <= 1'b0;
      sig_wr_addr  <= '0;
      mat_wr_en    <= 1'b0;
      mat_wr_addr  <= '0;
      cfg_wr_data  <= '0;
      core_enable  <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else begin
      rdy_en    <= 1'b1;
      sig_wr_en <= sig_go;
      mat_wr_en <= mat_go;
      if (aw_hs) aw_q <= s_axi_awaddr[3:2];
      if (w_hs) w_q <= s_axi_wdata;
      if (sig_go) sig_wr_addr <= sig_cnt;
      if (mat_go) mat_wr_addr <= mat_cnt;
      if (sig_go || mat_go) cfg_wr_data <= data[CORRELATION_DATA_WIDTH-1:0];
      if (fire) s_axi_bresp <= resp_n;
      if (clr) core_enable <= 1'b0;
      else if (ctrl_wr) core_enable <= data[0] && sig_loaded && mat_loaded;
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_val;
      end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  end
  sm_cfg_index_counter #(.LIMIT(NUM_BANDS)) u_sig_cnt (
    .clk(clk), .reset(reset), .clear(clr), .inc(sig_go), .cnt(sig_cnt), .loaded(sig_loaded)
  );
  sm_cfg_index_counter #(.LIMIT(NUM_BANDS * NUM_BANDS)) u_mat_cnt (
    .clk(clk), .reset(reset), .clear(clr), .inc(mat_go), .cnt(mat_cnt), .loaded(mat_loaded)
  );
endmodule

// File: tb/tb_sm_config_loader.sv
// tb_sm_config_loader: randomized AXI-Lite traffic checked against a counting model of the loader.
module tb_sm_config_loader;
  localparam int NB = 16;
  localparam int NM = NB * NB;
  logic clk = 0, reset = 1;
  logic [3:0] s_axi_awaddr = 0, s_axi_araddr = 0;
  logic s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
  logic [31:0] s_axi_wdata = 0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, cfg_wr_data;
  logic sig_wr_en, mat_wr_en, core_enable;
  logic [3:0] sig_wr_addr;
  logic [7:0] mat_wr_addr;
  always #5 clk = ~clk;
  sm_config_loader dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .sig_wr_en(sig_wr_en), .sig_wr_addr(sig_wr_addr), .mat_wr_en(mat_wr_en), .mat_wr_addr(mat_wr_addr),
    .cfg_wr_data(cfg_wr_data), .core_enable(core_enable)
  );
  int vecs = 0, errs = 0;
  int m_sig = 0, m_mat = 0;
  bit m_sig_full = 0, m_mat_full = 0, m_en = 0;
  typedef struct {int kind; int idx; logic [31:0] data;} strobe_t;
  strobe_t sq[$];
  always @(negedge clk) if (!reset) begin
    if (sig_wr_en) sq.push_back('{2, int'(sig_wr_addr), cfg_wr_data});
    if (mat_wr_en) sq.push_back('{1, int'(mat_wr_addr), cfg_wr_data});
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_sig = 0; m_mat = 0; m_sig_full = 0; m_mat_full = 0; m_en = 0;
  endtask
  // kind: 0 none, 1 matrix strobe, 2 signature strobe
  task automatic model_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] er, output int ek, output int ei);
    er = 2'b00; ek = 0; ei = 0;
    case (a[3:2])
      2'd0: if (d[1]) model_reset();
            else if (d[0]) begin m_en = m_sig_full && m_mat_full; if (!m_en) er = 2'b10; end
            else m_en = 0;
      2'd1: if (m_mat_full) er = 2'b10;
            else begin ek = 1; ei = m_mat; m_mat++; if (m_mat == NM) begin m_mat_full = 1; m_mat = 0; end end
      2'd2: if (m_sig_full) er = 2'b10;
            else begin ek = 2; ei = m_sig; m_sig++; if (m_sig == NB) begin m_sig_full = 1; m_sig = 0; end end
      default: er = 2'b10;
    endcase
  endtask
  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input int lead, input int bdly,
                          output logic [1:0] resp, output logic en_b, output logic [1:0] st);
    int aw_at, w_at, c;
    bit aw_done, w_done;
    logic aw_go, w_go;
    aw_at = lead > 0 ? lead : 0;
    w_at = lead < 0 ? -lead : 0;
    aw_done = 0; w_done = 0; c = 0;
    while (!(aw_done && w_done) && c < 40) begin
      if (c == aw_at && !aw_done) begin s_axi_awaddr = a; s_axi_awvalid = 1; end
      if (c == w_at && !w_done) begin s_axi_wdata = d; s_axi_wvalid = 1; end
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (aw_go) begin s_axi_awvalid = 0; aw_done = 1; end
      if (w_go) begin s_axi_wvalid = 0; w_done = 1; end
      c++;
    end
    if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    c = 0;
    while (!s_axi_bvalid && c < 20) begin @(posedge clk); #1; c++; end
    check("bvalid_latency", c, 0);
    resp = s_axi_bresp; en_b = core_enable; st = {sig_wr_en, mat_wr_en};
    repeat (bdly) begin @(posedge clk); #1; check("bvalid_hold", s_axi_bvalid, 1); end
    s_axi_bready = 1;
    @(posedge clk); #1;
    s_axi_bready = 0;
    check("bvalid_drop", s_axi_bvalid, 0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input int lead, input int bdly);
    logic [1:0] er, gr, st;
    int ek, ei;
    logic en_b;
    model_write(a, d, er, ek, ei);
    do_write(a, d, lead, bdly, gr, en_b, st);
    check("bresp", gr, er);
    check("en_at_bvalid", en_b, m_en);
    check("strobe_at_bvalid", st, ek == 2 ? 2'b10 : ek == 1 ? 2'b01 : 2'b00);
    check("strobe_count", sq.size(), ek != 0);
    if (ek != 0 && sq.size() == 1) begin
      check("strobe_kind", sq[0].kind, ek);
      check("strobe_addr", sq[0].idx, ei);
      check("strobe_data", sq[0].data, d);
    end
    sq.delete();
  endtask
  task automatic rd(input logic [3:0] a, input int rdly);
    logic [31:0] exp;
    int c;
    exp = a[3:2] == 2'd0 ? {31'b0, m_en} :
          a[3:2] == 2'd3 ? {5'b0, m_en, m_mat_full, m_sig_full, 16'(m_mat), 8'(m_sig)} : 32'b0;
    s_axi_araddr = a; s_axi_arvalid = 1; c = 0;
    while (!s_axi_arready && c < 20) begin @(posedge clk); #1; c++; end
    @(posedge clk); #1;
    s_axi_arvalid = 0; c = 0;
    while (!s_axi_rvalid && c < 20) begin @(posedge clk); #1; c++; end
    check("rvalid", s_axi_rvalid, 1);
    check("rdata", s_axi_rdata, exp);
    check("rresp", s_axi_rresp, 0);
    repeat (rdly) begin @(posedge clk); #1; check("rvalid_hold", s_axi_rvalid, 1); end
    s_axi_rready = 1;
    @(posedge clk); #1;
    s_axi_rready = 0;
    check("rvalid_drop", s_axi_rvalid, 0);
  endtask
  function automatic int rlead();
    return int'($urandom_range(0, 6)) - 3;
  endfunction
  initial begin
    int c;
    logic [3:0] a;
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_strobes", {sig_wr_en, mat_wr_en, core_enable}, 0);
    check("rst_addr", {sig_wr_addr, mat_wr_addr, s_axi_rdata, s_axi_bresp}, 0);
    reset = 0;
    @(posedge clk); #1;
    rd(4'hC, 0);
    for (int i = 0; i < NB; i++) wr(4'h8, 32'd500000000, rlead(), 0);
    rd(4'hC, 1);
    wr(4'h0, 32'h1, 0, 0);
    for (int i = 0; i < NM; i++) wr(4'h4, $urandom, rlead(), $urandom_range(0, 1));
    wr(4'h4, 32'hDEAD_BEEF, 0, 0);
    rd(4'hC, 0);
    wr(4'h0, 32'h1, 0, 0);
    rd(4'h0, 2);
    wr(4'h8, 32'h1234_5678, 3, 5);
    wr(4'h8, 32'h1234_5678, 0, 5);
    wr(4'hC, 32'hFFFF_FFFF, -2, 0);
    rd(4'h4, 0);
    rd(4'h8, 0);
    wr(4'h0, 32'h3, 0, 0);
    rd(4'hC, 0);
    for (int i = 0; i < NB; i++) wr(4'h8, $urandom, rlead(), 0);
    for (int i = 0; i < 400; i++) begin
      c = $urandom_range(0, 9);
      a = c < 4 ? 4'h4 : c < 7 ? 4'h8 : c < 9 ? 4'h0 : 4'hC;
      d = a == 4'h0 ? ($urandom_range(0, 15) == 0 ? 32'h2 : 32'($urandom_range(0, 1))) : $urandom;
      wr(a, d, rlead(), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rd({$urandom_range(0, 3), 2'b00}, $urandom_range(0, 2));
    end
    s_axi_awaddr = 4'h8; s_axi_awvalid = 1; c = 0;
    while (!s_axi_awready && c < 20) begin @(posedge clk); #1; c++; end
    @(posedge clk); #1;
    s_axi_awvalid = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    check("midrst_bvalid", s_axi_bvalid, 0);
    check("midrst_enable", core_enable, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_strobe", sq.size(), 0);
    check("midrst_bvalid_idle", s_axi_bvalid, 0);
    sq.delete();
    rd(4'hC, 0);
    wr(4'h8, 32'hCAFE_F00D, 0, 0);
    wr(4'h4, 32'h0BAD_CAFE, -1, 1);
    rd(4'hC, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
